fir_param_pipe: RTL

//  Parametrised, pipelined direct-form FIR (ORDER+1 taps). Next-generation lab filter.

---
 rtl/fir_pkg.sv | 48 ++++
 rtl/fir_out_stage.sv | 40 ++++
 rtl/fir_param_pipe.sv | 107 ++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared configuration, types and output conditioning for the pipelined FIR.
// Data/coefficient/output widths and the filter order are set here; the
// derived widths guarantee the tap sum never overflows internally.
package fir_pkg;

  localparam int ORDER = 8;
  localparam int DW    = 11;
  localparam int CW    = 11;
  localparam int OW    = 11;

  localparam int NT = ORDER + 1;
  localparam int AW = $clog2(NT);
  localparam int PW = DW + CW;
  localparam int SW = PW + $clog2(NT);

  typedef logic signed [DW-1:0] samp_t;
  typedef logic signed [CW-1:0] coef_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [SW-1:0] sum_t;
  typedef logic signed [OW-1:0] word_t;

  typedef struct packed {
    logic  ovf;
    word_t word;
  } sat_res_t;

  // Representable output range expressed at sum width for signed compares.
  localparam sum_t Y_MAX = sum_t'((2 ** (OW - 1)) - 1);
  localparam sum_t Y_MIN = sum_t'(-(2 ** (OW - 1)));

  // Rescale the Q1.(CW-1) weighted sum back to sample units (floor), flag
  // out-of-range results, then clamp or wrap to the output width.
  function automatic sat_res_t sat_trunc(input sum_t sum, input logic sat);
    sum_t     y;
    sat_res_t r;
    y     = sum >>> (CW - 1);
    r.ovf = (y > Y_MAX) || (y < Y_MIN);
    if (sat && (y > Y_MAX)) begin
      r.word = Y_MAX[OW-1:0];
    end else if (sat && (y < Y_MIN)) begin
      r.word = Y_MIN[OW-1:0];
    end else begin
      r.word = y[OW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_out_stage.sv
// Final pipeline stage: converts the full-precision tap sum into the output
// word (saturate or wrap, chosen at build time) and registers DOUT/VOUT/OVF.
// DOUT and OVF only change on a valid output so they hold between samples.
module fir_out_stage
  import fir_pkg::*;
#(
  parameter bit SAT = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  sum_t  sum,
  input  logic  valid,
  output word_t dout,
  output logic  vout,
  output logic  ovf
);

  sat_res_t res;

  // Combinational shift, range check and clamp/wrap of the tap sum.
  always_comb begin
    res = sat_trunc(sum, SAT);
  end

  // Stage C registers; data and flag update only alongside a valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      vout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      vout <= valid;
      if (valid) begin
        dout <= res.word;
        ovf  <= res.ovf;
      end
    end
  end

endmodule

// File: rtl/fir_param_pipe.sv
// Pipelined direct-form FIR with double-buffered runtime coefficients.
// Stage A shifts the delay line, stage B registers per-tap products against
// the active bank, stage C (fir_out_stage) registers the conditioned result.
// A commit copies the whole shadow bank in one edge, so every output is
// computed from a single coherent coefficient set.
module fir_param_pipe
  import fir_pkg::*;
#(
  parameter bit SAT = 1'b1
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic [DW-1:0] DIN,
  input  logic          VIN,
  input  logic          CLR,
  input  logic          H_WE,
  input  logic [AW-1:0] H_ADDR,
  input  logic [CW-1:0] H_DATA,
  input  logic          H_COMMIT,
  output logic [OW-1:0] DOUT,
  output logic          VOUT,
  output logic          OVF
);

  samp_t x      [NT];
  coef_t shadow [NT];
  coef_t active [NT];
  prod_t prod   [NT];
  logic  v_a;
  logic  v_b;
  logic  v_c;
  sum_t  sum;
  word_t dout_w;

  // Stage A: delay line advances only on valid samples; flush zeroes it and
  // discards any sample presented on the same edge.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NT; i++) x[i] <= '0;
      v_a <= 1'b0;
    end else if (CLR) begin
      for (int i = 0; i < NT; i++) x[i] <= '0;
      v_a <= 1'b0;
    end else begin
      v_a <= VIN;
      if (VIN) begin
        x[0] <= samp_t'(DIN);
        for (int i = 1; i < NT; i++) x[i] <= x[i-1];
      end
    end
  end

  // Coefficient banks: writes land in shadow only (out-of-range taps match
  // no entry); commit copies the pre-edge shadow contents to active.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NT; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NT; i++) begin
        if (H_WE && (H_ADDR == AW'(i))) shadow[i] <= coef_t'(H_DATA);
      end
      if (H_COMMIT) begin
        for (int i = 0; i < NT; i++) active[i] <= shadow[i];
      end
    end
  end

  // Stage B: per-tap products against the bank active before this edge.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NT; i++) prod[i] <= '0;
      v_b <= 1'b0;
    end else begin
      v_b <= v_a & ~CLR;
      if (v_a) begin
        for (int i = 0; i < NT; i++) prod[i] <= prod_t'(x[i]) * prod_t'(active[i]);
      end
    end
  end

  // Full-precision tap sum; SW leaves headroom for NT worst-case products.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NT; i++) sum = sum + sum_t'(prod[i]);
  end

  // A flush also kills the sample that would reach stage C on this edge.
  assign v_c = v_b & ~CLR;

  fir_out_stage #(
    .SAT (SAT)
  ) u_out (
    .clk   (CLK),
    .rst_n (RST_n),
    .sum   (sum),
    .valid (v_c),
    .dout  (dout_w),
    .vout  (VOUT),
    .ovf   (OVF)
  );

  assign DOUT = dout_w;

endmodule
